// File: rtl/logic_gate_pkg.sv
// Shared definitions for the two-input gate tester: FSM states, vector count
// and the truth tables the responses are checked against.
package logic_gate_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  localparam int unsigned NUM_VECTORS = 4;
  localparam int unsigned LAST_VECTOR = NUM_VECTORS - 1;

  // Truth tables indexed by the vector {a,b}; bit v is the expected output for vector v.
  localparam logic [NUM_VECTORS-1:0] EXP_AND = 4'b1000;
  localparam logic [NUM_VECTORS-1:0] EXP_OR  = 4'b1110;
  localparam logic [NUM_VECTORS-1:0] EXP_NOT = 4'b0011;

endpackage

// File: rtl/gate_golden.sv
// Combinational reference gate unit: looks up the expected AND/OR/NOT of a
// stimulus pair in the shared truth tables.
module gate_golden
  import logic_gate_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic andOut,
  output logic orOut,
  output logic notOut
);

  logic [1:0] idx;

  assign idx    = {a, b};
  assign andOut = EXP_AND[idx];
  assign orOut  = EXP_OR[idx];
  assign notOut = EXP_NOT[idx];

endmodule

// File: rtl/logic_gate_tester.sv
// Walks the four input vectors through an external two-input gate unit and
// records which vectors produced a wrong response. Optional mismatch counter
// output oErrCnt is built when GATE_TEST_ERRCNT_EN is defined.
//
// Handshake: iStart is a single-cycle request, honoured only while oBusy=0 and
// not in the oDone cycle; the result (oPass/oFailMask) is valid from the oDone
// pulse until the next accepted iStart.
module logic_gate_tester
  import logic_gate_pkg::*;
#(
  parameter int unsigned SETTLE = 2
)
(
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iStart,
  input  logic       iAnd,
  input  logic       iOr,
  input  logic       iNot,
  output logic       oA,
  output logic       oB,
  output logic       oBusy,
  output logic       oDone,
  output logic       oPass,
  output logic [3:0] oFailMask
`ifdef GATE_TEST_ERRCNT_EN
  ,
  output logic [3:0] oErrCnt
`endif
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE);

  state_e     state, stateNext;
  logic [1:0] vec, vecNext;
  logic [3:0] cnt, cntNext;
  logic [3:0] failMask, failMaskNext;
  logic       passQ, passNext;

  logic       expAnd, expOr, expNot;
  logic [2:0] mismatch;
  logic       startAccept;

  gate_golden uGolden (
    .a      (vec[1]),
    .b      (vec[0]),
    .andOut (expAnd),
    .orOut  (expOr),
    .notOut (expNot)
  );

  assign mismatch    = {iAnd ^ expAnd, iOr ^ expOr, iNot ^ expNot};
  assign startAccept = (state == S_IDLE) && iStart;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state    <= S_IDLE;
      vec      <= 2'd0;
      cnt      <= 4'd0;
      failMask <= 4'd0;
      passQ    <= 1'b0;
    end else begin
      state    <= stateNext;
      vec      <= vecNext;
      cnt      <= cntNext;
      failMask <= failMaskNext;
      passQ    <= passNext;
    end
  end

  always_comb begin
    stateNext    = state;
    vecNext      = vec;
    cntNext      = cnt;
    failMaskNext = failMask;
    passNext     = passQ;
    case (state)
      S_IDLE: begin
        if (iStart) begin
          failMaskNext = 4'd0;
          passNext     = 1'b0;
          vecNext      = 2'd0;
          stateNext    = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (SETTLE == 0) begin
          stateNext = S_CHECK;
        end else begin
          cntNext   = SETTLE_LOAD;
          stateNext = S_SETTLE;
        end
      end
      S_SETTLE: begin
        // Counter holds the remaining wait cycles including the current one.
        cntNext = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
        if (cnt <= 4'd1) begin
          stateNext = S_CHECK;
        end
      end
      S_CHECK: begin
        if (|mismatch) begin
          failMaskNext[vec] = 1'b1;
        end
        if (vec == 2'(LAST_VECTOR)) begin
          passNext  = (failMaskNext == 4'd0);
          stateNext = S_DONE;
        end else begin
          vecNext   = vec + 2'd1;
          stateNext = S_DRIVE;
        end
      end
      S_DONE: begin
        stateNext = S_IDLE;
      end
      default: begin
        stateNext = S_IDLE;
      end
    endcase
  end

  assign oBusy     = (state == S_DRIVE) || (state == S_SETTLE) || (state == S_CHECK);
  assign oDone     = (state == S_DONE);
  assign oA        = oBusy & vec[1];
  assign oB        = oBusy & vec[0];
  assign oPass     = passQ;
  assign oFailMask = failMask;

`ifdef GATE_TEST_ERRCNT_EN
  logic [3:0] errCnt;
  logic [1:0] mismatchBits;

  assign mismatchBits = 2'(mismatch[0]) + 2'(mismatch[1]) + 2'(mismatch[2]);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      errCnt <= 4'd0;
    end else if (startAccept) begin
      errCnt <= 4'd0;
    end else if (state == S_CHECK) begin
      errCnt <= errCnt + 4'(mismatchBits);
    end
  end

  assign oErrCnt = errCnt;
`else
  logic unusedStart;
  assign unusedStart = startAccept;
`endif

endmodule

// File: tb/tb_logic_gate_tester.sv
// Bench for logic_gate_tester: two instances (SETTLE=2 and SETTLE=0) each
// driving a behavioural gate unit whose faults are chosen per pass.
module tb_logic_gate_tester;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Gate-unit fault modes: 0 healthy, 1 AND stuck-at-0, 2 NOT returns A, 3 per-vector flips.
  int         mode = 0;
  logic [2:0] flip [4];

  logic start2 = 1'b0, start0 = 1'b0;
  logic and2, or2, not2, and0, or0, not0;
  logic a2, b2, busy2, done2, pass2, a0, b0, busy0, done0, pass0;
  logic [3:0] mask2, mask0;
`ifdef GATE_TEST_ERRCNT_EN
  logic [3:0] err2, err0;
`endif

  int compared = 0;
  int mismatched = 0;

  function automatic logic [2:0] gate_resp(input logic a, input logic b);
    logic [2:0] r;
    r = {a & b, a | b, ~a};
    case (mode)
      1: r[2] = 1'b0;
      2: r[0] = a;
      3: r = r ^ flip[{a, b}];
      default: ;
    endcase
    return r;
  endfunction

  always_comb {and2, or2, not2} = gate_resp(a2, b2);
  always_comb {and0, or0, not0} = gate_resp(a0, b0);

  logic_gate_tester #(.SETTLE(2)) dut (
    .iClk(clk), .iRst_n(rst_n), .iStart(start2),
    .iAnd(and2), .iOr(or2), .iNot(not2),
    .oA(a2), .oB(b2), .oBusy(busy2), .oDone(done2), .oPass(pass2), .oFailMask(mask2)
`ifdef GATE_TEST_ERRCNT_EN
    , .oErrCnt(err2)
`endif
  );

  logic_gate_tester #(.SETTLE(0)) dut0 (
    .iClk(clk), .iRst_n(rst_n), .iStart(start0),
    .iAnd(and0), .iOr(or0), .iNot(not0),
    .oA(a0), .oB(b0), .oBusy(busy0), .oDone(done0), .oPass(pass0), .oFailMask(mask0)
`ifdef GATE_TEST_ERRCNT_EN
    , .oErrCnt(err0)
`endif
  );

  // Selected-instance view used by the pass runner.
  logic       selZ = 1'b0;
  logic       sA, sB, sBusy, sDone, sPass;
  logic [3:0] sMask, sErr;
  assign sA    = selZ ? a0 : a2;
  assign sB    = selZ ? b0 : b2;
  assign sBusy = selZ ? busy0 : busy2;
  assign sDone = selZ ? done0 : done2;
  assign sPass = selZ ? pass0 : pass2;
  assign sMask = selZ ? mask0 : mask2;
`ifdef GATE_TEST_ERRCNT_EN
  assign sErr  = selZ ? err0 : err2;
`else
  assign sErr  = 4'd0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected results derived from the truth table and the fault model response.
  task automatic reference(output logic [3:0] expMask, output int expErr);
    logic [2:0] truth, resp, diff;
    expMask = 4'd0;
    expErr  = 0;
    for (int v = 0; v < 4; v++) begin
      truth = {v[1] & v[0], v[1] | v[0], ~v[1]};
      resp  = gate_resp(v[1], v[0]);
      diff  = truth ^ resp;
      if (diff != 3'd0) expMask[v] = 1'b1;
      expErr += $countones(diff);
    end
  endtask

  task automatic set_start(input logic val);
    if (selZ) start0 = val;
    else      start2 = val;
  endtask

  task automatic run_pass(input logic useZero, input string tag, input bit repulse);
    int settle, expLat, edges, busyCycles, extraDone, expErr;
    logic [3:0] expMask;
    selZ   = useZero;
    settle = useZero ? 0 : 2;
    expLat = 4 * (settle + 2);
    reference(expMask, expErr);
    @(negedge clk);
    set_start(1'b1);
    @(posedge clk);
    #1 set_start(1'b0);
    edges = 0;
    busyCycles = 0;
    while (!sDone && edges < 200) begin
      if (sBusy) begin
        busyCycles++;
        check({tag, "_vec"}, {30'd0, sA, sB}, edges / (settle + 2));
      end
      @(posedge clk);
      edges++;
      #1;
      set_start(repulse && (edges == 5 || edges == 9));
    end
    set_start(1'b0);
    check({tag, "_latency"}, edges, expLat);
    check({tag, "_busy_cycles"}, busyCycles, expLat);
    check({tag, "_done"}, sDone, 1'b1);
    check({tag, "_busy_at_done"}, sBusy, 1'b0);
    check({tag, "_ab_at_done"}, {sA, sB}, 2'b00);
    check({tag, "_pass"}, sPass, expMask == 4'd0);
    check({tag, "_mask"}, sMask, expMask);
`ifdef GATE_TEST_ERRCNT_EN
    check({tag, "_errcnt"}, sErr, expErr);
`endif
    extraDone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (sDone) extraDone++;
    end
    check({tag, "_single_done"}, extraDone, 0);
    check({tag, "_hold_pass"}, sPass, expMask == 4'd0);
    check({tag, "_hold_mask"}, sMask, expMask);
    check({tag, "_idle_busy"}, sBusy, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, {busy2, busy0}, 2'b00);
    check({tag, "_done"}, {done2, done0}, 2'b00);
    check({tag, "_pass"}, {pass2, pass0}, 2'b00);
    check({tag, "_mask"}, {mask2, mask0}, 8'h00);
    check({tag, "_ab"}, {a2, b2, a0, b0}, 4'h0);
`ifdef GATE_TEST_ERRCNT_EN
    check({tag, "_errcnt"}, {err2, err0}, 8'h00);
`endif
  endtask

  initial begin
    for (int v = 0; v < 4; v++) flip[v] = 3'd0;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    mode = 0;
    run_pass(1'b0, "clean_s2", 1'b0);
    mode = 1;
    run_pass(1'b0, "and_stuck0", 1'b0);
    mode = 2;
    run_pass(1'b0, "not_is_a", 1'b0);
    mode = 0;
    run_pass(1'b1, "clean_s0", 1'b0);
    run_pass(1'b0, "repulse", 1'b1);

    mode = 3;
    for (int n = 0; n < 8; n++) begin
      for (int v = 0; v < 4; v++)
        flip[v] = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 7)) : 3'd0;
      run_pass(1'(n % 2), "random", 1'b0);
    end

    // Reset in the middle of the vector-2 check, with failures already recorded.
    for (int v = 0; v < 4; v++) flip[v] = 3'd0;
    flip[0] = 3'b011;
    selZ = 1'b0;
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check("pre_reset_busy", busy2, 1'b1);
    check("pre_reset_vec", {a2, b2}, 2'b10);
    check("pre_reset_mask", mask2, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    mode = 0;
    run_pass(1'b0, "after_reset", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/logic_gate_tester.md
LOGIC_GATE_TESTER -- requirements
Module: logic_gate_tester

Interface
REQ-001 Parameter: SETTLE, 2, idle cycles between driving a vector and sampling responses; legal range 0..15.
REQ-002 Port: iClk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: iRst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: iStart  input  1  one-cycle request to run a full test pass.
REQ-005 Port: iAnd, iOr, iNot  input  1 each  responses from the two-input gate unit under test.
REQ-006 Port: oA, oB  output  1 each  stimulus driven to the gate unit's iA/iB.
REQ-007 Port: oBusy  output  1  high while a pass is in progress.
REQ-008 Port: oDone  output  1  one-cycle pulse at end of pass.
REQ-009 Port: oPass  output  1  result of last completed pass; 1 = all checks matched.
REQ-010 Port: oFailMask  output  4  bit v set = vector v ({oA,oB}=v) had at least one mismatch.

Function
REQ-011 The FSM SHALL have the states IDLE, DRIVE, SETTLE, CHECK and DONE.
REQ-012 In IDLE, iStart=1 SHALL clear oFailMask, set vector index v=0 and move to DRIVE; in every other state iStart SHALL be ignored.
REQ-013 DRIVE SHALL present {oA,oB}=v for one cycle, then go to SETTLE (SETTLE>0) or CHECK (SETTLE=0).
REQ-014 SETTLE SHALL last exactly SETTLE cycles, counted by a 4-bit down-counter, then go to CHECK.
REQ-015 CHECK SHALL compare iAnd/iOr/iNot against expected A&B, A|B and ~A; any mismatch SHALL set oFailMask[v].
REQ-016 After CHECK, v<3 SHALL increment v and go to DRIVE; v=3 SHALL go to DONE without wrapping v.
REQ-017 DONE SHALL last one cycle with oDone=1 and oPass=(oFailMask==0), then return to IDLE.
REQ-018 oA/oB SHALL hold the current vector through DRIVE, SETTLE and CHECK, and return to 0 in IDLE and DONE.
REQ-019 oBusy SHALL be 1 in DRIVE, SETTLE and CHECK, and 0 in IDLE and DONE.
REQ-020 Latency: oDone SHALL be high in the cycle after the 4*(SETTLE+2)-th rising edge following the edge that samples iStart.
REQ-021 oPass and oFailMask SHALL hold their values until the next accepted iStart.

Reset
REQ-022 Asserting iRst_n low SHALL immediately force the state to IDLE, v=0, counter=0, oA=oB=0, oBusy=0, oDone=0, oPass=0 and oFailMask=0, including in the middle of a pass.
REQ-023 After iRst_n deasserts, the first iStart SHALL be accepted on the first rising edge.

Configuration
REQ-024 When the macro GATE_TEST_ERRCNT_EN is defined, a 4-bit output oErrCnt SHALL exist; it SHALL be cleared on accepted iStart and reset, and SHALL increase in CHECK by the number of mismatching response bits (0..3), giving a maximum of 12.
REQ-025 When GATE_TEST_ERRCNT_EN is undefined, the oErrCnt port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-026 A shared package logic_gate_pkg SHALL hold the FSM state enumeration, the vector count (4) and the expected truth-table constants.
REQ-027 The expected-value function SHALL be a combinational sub-module gate_golden (inputs a, b; outputs and/or/not), instantiated once.

Verification
REQ-028 Correct gate model, SETTLE=2, iStart pulse -> oDone high in the cycle after the 16th edge; oPass=1, oFailMask=4'b0000, oErrCnt=0.
REQ-029 iAnd stuck-at-0 -> oPass=0, oFailMask=4'b1000, oErrCnt=1.
REQ-030 iNot wired as iA instead of ~iA -> oFailMask=4'b1111, oErrCnt=4.
REQ-031 SETTLE=0, correct model -> oDone in the cycle after the 8th edge; oBusy high for exactly 8 cycles.
REQ-032 iStart re-pulsed while oBusy=1 -> ignored; a single oDone pulse; timing identical to REQ-028.
REQ-033 iRst_n low during CHECK of vector 2 -> all outputs reach their reset values asynchronously; a new iStart then completes a clean pass with oPass=1.
